rf80386_ibyte_queue: RTL and testbench

//  Parametrised instruction-byte prefetch queue for the rf80386 core.
//  - Fetches aligned code lines from the I-cache into a circular byte buffer.
//  - Gives the decoder a TAKE_MAX-byte peek window; the decoder consumes a

---
 rtl/rf80386_ibyte_queue.sv | 135 +++++++++++++
 tb/tb_rf80386_ibyte_queue.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rf80386_ibyte_queue.sv
// Instruction-byte prefetch queue: aligned I-cache lines in, TAKE_MAX-byte peek window out.
// Lines become visible one cycle after acceptance; requests stop while a full line will not fit.
module rf80386_ibyte_queue #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned TAKE_MAX   = 4,
  parameter logic [7:0]  FILL_BYTE  = 8'h90,
  parameter logic [31:0] RESET_PC   = 32'h000F0000,
  localparam int unsigned CAP = LINE_BYTES * DEPTH,
  localparam int unsigned CW  = $clog2(CAP + 1),
  localparam int unsigned TW  = $clog2(TAKE_MAX + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [31:0]             flush_adr_i,
  output logic                    fetch_req_o,
  output logic [31:0]             fetch_adr_o,
  input  logic                    fetch_ack_i,
  input  logic [LINE_BYTES*8-1:0] fetch_line_i,
  output logic [TAKE_MAX*8-1:0]   peek_o,
  output logic [CW-1:0]           valid_cnt_o,
  output logic [31:0]             pc_o,
  input  logic [TW-1:0]           take_i,
  output logic                    underrun_o
);

  localparam int unsigned PW = $clog2(CAP);
  localparam int unsigned LW = $clog2(LINE_BYTES);
  localparam logic [31:0] ADR_MASK = ~(32'(LINE_BYTES) - 32'd1);

  typedef enum logic {S_WAIT, S_FETCH} state_t;

  state_t          state_q, state_d;
  logic [7:0]      buf_q [CAP];
  logic [7:0]      buf_d [CAP];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     pc_q, pc_d, fadr_q, fadr_d;
  logic [LW-1:0]   skip_q, skip_d;
  logic            underrun_q, underrun_d;
  logic            accept;
  logic [CW-1:0]   written, take_w, eff;

  // Offsets never exceed CAP, so a single conditional subtract is a full modulo.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= int'(CAP)) s = s - int'(CAP);
    return s[PW-1:0];
  endfunction

  always_comb begin
    buf_d      = buf_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    pc_d       = pc_q;
    fadr_d     = fadr_q;
    skip_d     = skip_q;
    underrun_d = 1'b0;
    state_d    = state_q;

    accept  = (state_q == S_FETCH) && fetch_ack_i && !flush_i;
    written = accept ? (CW'(LINE_BYTES) - CW'(skip_q)) : '0;
    take_w  = CW'(take_i);
    eff     = (take_w > count_q) ? count_q : take_w;

    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      pc_d    = flush_adr_i;
      skip_d  = flush_adr_i[LW-1:0];
      fadr_d  = flush_adr_i & ADR_MASK;
    end else begin
      for (int j = 0; j < int'(LINE_BYTES); j++) begin
        if (accept && (j >= int'(skip_q)))
          buf_d[wrap_add(wr_q, j - int'(skip_q))] = fetch_line_i[j*8 +: 8];
      end
      if (accept) begin
        wr_d   = wrap_add(wr_q, int'(written));
        fadr_d = fadr_q + 32'(LINE_BYTES);
        skip_d = '0;
      end
      rd_d       = wrap_add(rd_q, int'(eff));
      pc_d       = pc_q + 32'(eff);
      count_d    = count_q + written - eff;
      underrun_d = take_w > count_q;
    end

    // Space check ignores next cycle's take, so a request never overruns unread bytes.
    state_d = ((CAP - 32'(count_d)) >= LINE_BYTES) ? S_FETCH : S_WAIT;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_WAIT;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      pc_q       <= RESET_PC;
      fadr_q     <= RESET_PC & ADR_MASK;
      skip_q     <= RESET_PC[LW-1:0];
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      fadr_q     <= fadr_d;
      skip_q     <= skip_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) buf_q <= buf_d;
  end

  always_comb begin
    peek_o = {TAKE_MAX{FILL_BYTE}};
    for (int i = 0; i < int'(TAKE_MAX); i++) begin
      if (i < int'(count_q)) peek_o[i*8 +: 8] = buf_q[wrap_add(rd_q, i)];
    end
  end

  assign fetch_req_o = (state_q == S_FETCH);
  assign fetch_adr_o = fadr_q;
  assign valid_cnt_o = count_q;
  assign pc_o        = pc_q;
  assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_rf80386_ibyte_queue.sv
// Bench for rf80386_ibyte_queue: directed vector table, reset-mid-fill sequence, and a
// byte-queue reference model checked every cycle under random acks, takes and flushes.
module tb_rf80386_ibyte_queue;

  logic         clk_i = 1'b0;
  logic         rst_i, flush_i, fetch_ack_i, fetch_req_o, underrun_o;
  logic [31:0]  flush_adr_i, fetch_adr_o, pc_o;
  logic [127:0] fetch_line_i;
  logic [31:0]  peek_o;
  logic [5:0]   valid_cnt_o;
  logic [2:0]   take_i;

  rf80386_ibyte_queue dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .flush_adr_i(flush_adr_i),
    .fetch_req_o(fetch_req_o), .fetch_adr_o(fetch_adr_o), .fetch_ack_i(fetch_ack_i),
    .fetch_line_i(fetch_line_i), .peek_o(peek_o), .valid_cnt_o(valid_cnt_o),
    .pc_o(pc_o), .take_i(take_i), .underrun_o(underrun_o)
  );

  always #5 clk_i = ~clk_i;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Reference model: expected byte stream pushed on accepted lines, popped on takes.
  logic [7:0]  mq [$];
  logic [31:0] mpc, madr;
  logic [3:0]  mskip;
  logic        mreq, mund;

  task automatic model_update(input logic r, input logic f, input logic [31:0] fa,
                              input logic a, input logic [127:0] ln, input logic [2:0] tk);
    int sz, eff;
    if (r) begin
      mq.delete(); mpc = 32'h000F0000; mskip = 4'h0; madr = 32'h000F0000;
      mreq = 1'b0; mund = 1'b0;
    end else if (f) begin
      mq.delete(); mpc = fa; mskip = fa[3:0]; madr = {fa[31:4], 4'h0};
      mreq = 1'b1; mund = 1'b0;
    end else begin
      sz  = mq.size();
      eff = (int'(tk) > sz) ? sz : int'(tk);
      mund = int'(tk) > sz;
      for (int k = 0; k < eff; k++) void'(mq.pop_front());
      mpc = mpc + 32'(eff);
      if (mreq && a) begin
        for (int j = int'(mskip); j < 16; j++) mq.push_back(ln[j*8 +: 8]);
        madr = madr + 32'd16;
        mskip = 4'h0;
      end
      mreq = (32 - mq.size()) >= 16;
    end
  endtask

  task automatic step(input logic r, input logic f, input logic [31:0] fa,
                      input logic a, input logic [127:0] ln, input logic [2:0] tk);
    rst_i = r; flush_i = f; flush_adr_i = fa; fetch_ack_i = a; fetch_line_i = ln; take_i = tk;
    model_update(r, f, fa, a, ln, tk);
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [127:0] line_of(input logic [7:0] base);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[i*8 +: 8] = base + 8'(i);
    return l;
  endfunction

  function automatic logic [31:0] model_peek();
    logic [31:0] p;
    for (int i = 0; i < 4; i++) p[i*8 +: 8] = (i < mq.size()) ? mq[i] : 8'h90;
    return p;
  endfunction

  task automatic check_outputs(input string tag, input logic [5:0] cnt, input logic [31:0] pc,
                               input logic req, input logic [31:0] adr, input logic und,
                               input logic [31:0] pk);
    check({tag, ".cnt"},   128'(valid_cnt_o), 128'(cnt));
    check({tag, ".pc"},    128'(pc_o),        128'(pc));
    check({tag, ".req"},   128'(fetch_req_o), 128'(req));
    check({tag, ".adr"},   128'(fetch_adr_o), 128'(adr));
    check({tag, ".under"}, 128'(underrun_o),  128'(und));
    check({tag, ".peek"},  128'(peek_o),      128'(pk));
  endtask

  typedef struct {
    logic        flush;
    logic [31:0] fadr;
    logic        ack;
    logic [7:0]  base;
    logic [2:0]  take;
    logic [5:0]  cnt;
    logic [31:0] pc;
    logic        req;
    logic [31:0] adr;
    logic        under;
    logic [31:0] peek;
  } vec_t;

  vec_t vt [23];

  initial begin
    logic [127:0] rl;
    logic         rf, ra;
    logic [31:0]  rfa;
    logic [2:0]   rt;

    //          flush  fadr          ack   base   take  cnt    pc            req   adr           und   peek
    vt[0]  = '{1'b0, 32'h0,        1'b1, 8'h00, 3'd0, 6'd16, 32'h000F0000, 1'b1, 32'h000F0010, 1'b0, 32'h03020100};
    vt[1]  = '{1'b1, 32'h00001007, 1'b0, 8'h00, 3'd0, 6'd0,  32'h00001007, 1'b1, 32'h00001000, 1'b0, 32'h90909090};
    vt[2]  = '{1'b0, 32'h0,        1'b1, 8'h20, 3'd0, 6'd9,  32'h00001007, 1'b1, 32'h00001010, 1'b0, 32'h2A292827};
    vt[3]  = '{1'b1, 32'h00002000, 1'b0, 8'h00, 3'd0, 6'd0,  32'h00002000, 1'b1, 32'h00002000, 1'b0, 32'h90909090};
    vt[4]  = '{1'b0, 32'h0,        1'b1, 8'h40, 3'd0, 6'd16, 32'h00002000, 1'b1, 32'h00002010, 1'b0, 32'h43424140};
    vt[5]  = '{1'b0, 32'h0,        1'b1, 8'h50, 3'd0, 6'd32, 32'h00002000, 1'b0, 32'h00002020, 1'b0, 32'h43424140};
    vt[6]  = '{1'b0, 32'h0,        1'b1, 8'h60, 3'd4, 6'd28, 32'h00002004, 1'b0, 32'h00002020, 1'b0, 32'h47464544};
    vt[7]  = '{1'b0, 32'h0,        1'b0, 8'h00, 3'd4, 6'd24, 32'h00002008, 1'b0, 32'h00002020, 1'b0, 32'h4B4A4948};
    vt[8]  = '{1'b0, 32'h0,        1'b0, 8'h00, 3'd4, 6'd20, 32'h0000200C, 1'b0, 32'h00002020, 1'b0, 32'h4F4E4D4C};
    vt[9]  = '{1'b0, 32'h0,        1'b0, 8'h00, 3'd4, 6'd16, 32'h00002010, 1'b1, 32'h00002020, 1'b0, 32'h53525150};
    vt[10] = '{1'b0, 32'h0,        1'b0, 8'h00, 3'd4, 6'd12, 32'h00002014, 1'b1, 32'h00002020, 1'b0, 32'h57565554};
    vt[11] = '{1'b0, 32'h0,        1'b1, 8'h60, 3'd4, 6'd24, 32'h00002018, 1'b0, 32'h00002030, 1'b0, 32'h5B5A5958};
    vt[12] = '{1'b0, 32'h0,        1'b0, 8'h00, 3'd4, 6'd20, 32'h0000201C, 1'b0, 32'h00002030, 1'b0, 32'h5F5E5D5C};
    vt[13] = '{1'b0, 32'h0,        1'b0, 8'h00, 3'd4, 6'd16, 32'h00002020, 1'b1, 32'h00002030, 1'b0, 32'h63626160};
    vt[14] = '{1'b0, 32'h0,        1'b0, 8'h00, 3'd4, 6'd12, 32'h00002024, 1'b1, 32'h00002030, 1'b0, 32'h67666564};
    vt[15] = '{1'b0, 32'h0,        1'b0, 8'h00, 3'd4, 6'd8,  32'h00002028, 1'b1, 32'h00002030, 1'b0, 32'h6B6A6968};
    vt[16] = '{1'b0, 32'h0,        1'b0, 8'h00, 3'd4, 6'd4,  32'h0000202C, 1'b1, 32'h00002030, 1'b0, 32'h6F6E6D6C};
    vt[17] = '{1'b0, 32'h0,        1'b0, 8'h00, 3'd2, 6'd2,  32'h0000202E, 1'b1, 32'h00002030, 1'b0, 32'h90906F6E};
    vt[18] = '{1'b0, 32'h0,        1'b0, 8'h00, 3'd3, 6'd0,  32'h00002030, 1'b1, 32'h00002030, 1'b1, 32'h90909090};
    vt[19] = '{1'b0, 32'h0,        1'b0, 8'h00, 3'd0, 6'd0,  32'h00002030, 1'b1, 32'h00002030, 1'b0, 32'h90909090};
    vt[20] = '{1'b0, 32'h0,        1'b1, 8'h70, 3'd0, 6'd16, 32'h00002030, 1'b1, 32'h00002040, 1'b0, 32'h73727170};
    vt[21] = '{1'b1, 32'h00003005, 1'b1, 8'h80, 3'd4, 6'd0,  32'h00003005, 1'b1, 32'h00003000, 1'b0, 32'h90909090};
    vt[22] = '{1'b0, 32'h0,        1'b0, 8'h00, 3'd0, 6'd0,  32'h00003005, 1'b1, 32'h00003000, 1'b0, 32'h90909090};

    step(1'b1, 1'b0, 32'h0, 1'b0, 128'h0, 3'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1, line_of(8'hEE), 3'd0);
    check_outputs("reset", 6'd0, 32'h000F0000, 1'b0, 32'h000F0000, 1'b0, 32'h90909090);

    step(1'b0, 1'b0, 32'h0, 1'b0, 128'h0, 3'd0);
    check_outputs("release", 6'd0, 32'h000F0000, 1'b1, 32'h000F0000, 1'b0, 32'h90909090);

    for (int r = 0; r < 23; r++) begin
      step(1'b0, vt[r].flush, vt[r].fadr, vt[r].ack, line_of(vt[r].base), vt[r].take);
      check_outputs($sformatf("vec%0d", r), vt[r].cnt, vt[r].pc, vt[r].req,
                    vt[r].adr, vt[r].under, vt[r].peek);
    end

    // Reset while a fetch is pending and acked: line must be dropped.
    step(1'b1, 1'b0, 32'h0, 1'b1, line_of(8'hA0), 3'd0);
    check_outputs("rst_mid", 6'd0, 32'h000F0000, 1'b0, 32'h000F0000, 1'b0, 32'h90909090);
    step(1'b0, 1'b0, 32'h0, 1'b1, line_of(8'hA0), 3'd0);
    check_outputs("rst_ack_ignored", 6'd0, 32'h000F0000, 1'b1, 32'h000F0000, 1'b0, 32'h90909090);
    step(1'b0, 1'b0, 32'h0, 1'b1, line_of(8'hB0), 3'd0);
    check_outputs("rst_refill", 6'd16, 32'h000F0000, 1'b1, 32'h000F0010, 1'b0, 32'hB3B2B1B0);

    // Random phase starts near the top of the address space to cross the 2^32 wrap.
    for (int c = 0; c < 10000; c++) begin
      rf  = (c == 0) || ($urandom_range(0, 499) == 0);
      rfa = (c == 0) ? 32'hFFFFFF83 : (32'hFFFFFF00 | 32'($urandom_range(0, 255)));
      ra  = ($urandom_range(0, 9) < 6);
      rt  = 3'($urandom_range(0, 4));
      rl  = {$urandom, $urandom, $urandom, $urandom};
      step(1'b0, rf, rfa, ra, rl, rt);
      check($sformatf("rand%0d.state", c),
            {24'h0, valid_cnt_o, pc_o, fetch_req_o, fetch_adr_o, underrun_o, peek_o},
            {24'h0, 6'(mq.size()), mpc, mreq, madr, mund, model_peek()});
      if (total - passed > 20) break;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
